alu_issue_seq: RTL and testbench

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

---
 rtl/alu_issue_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Issue sequencer: decodes one MIPS-style ALU instruction, drives a multi-cycle ALU, returns the result.
// Optional HI/LO registers with mfhi/mflo are enabled by defining ALU_ISSUE_HILO_EN.
module alu_issue_seq #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  input  logic        alu_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic        out_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_zero_q, out_zero_d, out_illegal_q, out_illegal_d;

  logic        dec_legal;
  logic [5:0]  dec_ctrl;
  logic [31:0] dec_a, dec_b, imm_sx, imm_zx;
  logic        sh_ok;
  logic [5:0]  sh_off, sh_base;

`ifdef ALU_ISSUE_HILO_EN
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mf_val;
  logic        dec_mf, dec_mfhi;
`else
  logic        unused_r2;
  assign unused_r2 = ^alu_r2;
`endif

  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};

  // Instruction decode: operand selection and ALU control code
  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = 6'h00;
    dec_a     = rs_val;
    dec_b     = rt_val;
    sh_ok     = 1'b0;
    sh_off    = 6'h00;
    sh_base   = 6'h10;
`ifdef ALU_ISSUE_HILO_EN
    dec_mf    = 1'b0;
    dec_mfhi  = 1'b0;
`endif
    case (shamt)
      5'd1:    begin sh_ok = 1'b1; sh_off = 6'h00; end
      5'd2:    begin sh_ok = 1'b1; sh_off = 6'h01; end
      5'd8:    begin sh_ok = 1'b1; sh_off = 6'h02; end
      default: begin sh_ok = 1'b0; sh_off = 6'h00; end
    endcase
    if (funct == 6'h00)      sh_base = 6'h0A;
    else if (funct == 6'h02) sh_base = 6'h0D;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24: begin dec_legal = 1'b1; dec_ctrl = 6'h00; end
          6'h25: begin dec_legal = 1'b1; dec_ctrl = 6'h01; end
          6'h20: begin dec_legal = 1'b1; dec_ctrl = 6'h02; end
          6'h21: begin dec_legal = 1'b1; dec_ctrl = 6'h03; end
          6'h26: begin dec_legal = 1'b1; dec_ctrl = 6'h04; end
          6'h22: begin dec_legal = 1'b1; dec_ctrl = 6'h06; end
          6'h2A: begin dec_legal = 1'b1; dec_ctrl = 6'h07; end
          6'h2B: begin dec_legal = 1'b1; dec_ctrl = 6'h08; end
          6'h19: begin dec_legal = 1'b1; dec_ctrl = 6'h13; end
          6'h00, 6'h02, 6'h03: begin
            dec_legal = sh_ok;
            dec_ctrl  = sh_base + sh_off;
          end
`ifdef ALU_ISSUE_HILO_EN
          6'h10: begin dec_mf = 1'b1; dec_mfhi = 1'b1; end
          6'h12: dec_mf = 1'b1;
`endif
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_legal = 1'b1; dec_ctrl = 6'h02; dec_b = imm_sx; end
      6'h09: begin dec_legal = 1'b1; dec_ctrl = 6'h03; dec_b = imm_sx; end
      6'h0A: begin dec_legal = 1'b1; dec_ctrl = 6'h07; dec_b = imm_sx; end
      6'h0B: begin dec_legal = 1'b1; dec_ctrl = 6'h08; dec_b = imm_sx; end
      6'h0C: begin dec_legal = 1'b1; dec_ctrl = 6'h00; dec_b = imm_zx; end
      6'h0D: begin dec_legal = 1'b1; dec_ctrl = 6'h01; dec_b = imm_zx; end
      6'h0E: begin dec_legal = 1'b1; dec_ctrl = 6'h04; dec_b = imm_zx; end
      6'h0F: begin dec_legal = 1'b1; dec_ctrl = 6'h09; dec_b = imm_zx; end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_HILO_EN
  assign mf_val = dec_mfhi ? hi_q : lo_q;
`endif

  // Sequencer next state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    out_data_d    = out_data_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
`ifdef ALU_ISSUE_HILO_EN
    hi_d          = hi_q;
    lo_d          = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_ISSUE_HILO_EN
          if (dec_mf) begin
            state_d       = DONE;
            out_data_d    = mf_val;
            out_zero_d    = (mf_val == 32'h0);
            out_illegal_d = 1'b0;
          end else
`endif
          if (dec_legal) begin
            state_d       = EXEC;
            cnt_d         = 4'(EXEC_CYCLES - 1);
            alu_ctrl_d    = dec_ctrl;
            alu_a_d       = dec_a;
            alu_b_d       = dec_b;
            out_illegal_d = 1'b0;
          end else begin
            state_d       = DONE;
            out_data_d    = 32'h0;
            out_zero_d    = 1'b0;
            out_illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          out_data_d = alu_r;
          out_zero_d = alu_z;
`ifdef ALU_ISSUE_HILO_EN
          if (alu_ctrl_q == 6'h13) begin
            lo_d = alu_r;
            hi_d = alu_r2;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      alu_ctrl_q    <= 6'h00;
      alu_a_q       <= 32'h0;
      alu_b_q       <= 32'h0;
      out_data_q    <= 32'h0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_HILO_EN
      hi_q          <= 32'h0;
      lo_q          <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      out_data_q    <= out_data_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
`ifdef ALU_ISSUE_HILO_EN
      hi_q          <= hi_d;
      lo_q          <= lo_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_data    = out_data_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: an EXEC_CYCLES=1 instance driven through a scoreboard, and an EXEC_CYCLES=4 instance.
module tb_alu_issue_seq;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
  } ins_t;

  logic        clk;
  logic        rst_n1, rst_n4;
  logic        in_valid1, in_valid4, out_ready1, out_ready4;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm;

  logic        in_ready1, out_valid1, out_zero1, out_illegal1, alu_z1;
  logic [5:0]  alu_ctrl1;
  logic [31:0] alu_a1, alu_b1, alu_r1, alu_r2_1, out_data1;
  logic        in_ready4, out_valid4, out_zero4, out_illegal4, alu_z4;
  logic [5:0]  alu_ctrl4;
  logic [31:0] alu_a4, alu_b4, alu_r4, alu_r2_4, out_data4;

  int   nchk = 0;
  int   nerr = 0;
  exp_t exp_q[$];
`ifdef ALU_ISSUE_HILO_EN
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;
`endif

  alu_issue_seq #(.EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .alu_ctrl(alu_ctrl1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_r(alu_r1), .alu_r2(alu_r2_1), .alu_z(alu_z1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_zero(out_zero1), .out_illegal(out_illegal1)
  );

  alu_issue_seq #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .alu_ctrl(alu_ctrl4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_r(alu_r4), .alu_r2(alu_r2_4), .alu_z(alu_z4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_zero(out_zero4), .out_illegal(out_illegal4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU attached to each instance: returns {z, r2, r}
  function automatic logic [64:0] alu_model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] r2;
    logic [63:0] p;
    r  = 32'h0;
    r2 = 32'h0;
    p  = {32'h0, a} * {32'h0, b};
    case (c)
      6'h00: r = a & b;
      6'h01: r = a | b;
      6'h02, 6'h03: r = a + b;
      6'h04: r = a ^ b;
      6'h06: r = a - b;
      6'h07: r = {31'h0, $signed(a) < $signed(b)};
      6'h08: r = {31'h0, a < b};
      6'h09: r = b << 16;
      6'h0A: r = b << 1;
      6'h0B: r = b << 2;
      6'h0C: r = b << 8;
      6'h0D: r = b >> 1;
      6'h0E: r = b >> 2;
      6'h0F: r = b >> 8;
      6'h10: r = 32'($signed(b) >>> 1);
      6'h11: r = 32'($signed(b) >>> 2);
      6'h12: r = 32'($signed(b) >>> 8);
      6'h13: begin r = p[31:0]; r2 = p[63:32]; end
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), r2, r};
  endfunction

  assign {alu_z1, alu_r2_1, alu_r1} = alu_model(alu_ctrl1, alu_a1, alu_b1);
  assign {alu_z4, alu_r2_4, alu_r4} = alu_model(alu_ctrl4, alu_a4, alu_b4);

  // Instruction-level reference: what the instruction should return
  function automatic exp_t ref_exec(input ins_t i);
    exp_t        e;
    logic        ok;
    logic [31:0] v, sx, zx;
    logic [63:0] p;
    ok = 1'b1;
    v  = 32'h0;
    sx = {{16{i.im[15]}}, i.im};
    zx = {16'h0, i.im};
    p  = {32'h0, i.a} * {32'h0, i.b};
    if (i.op == 6'h00) begin
      case (i.fn)
        6'h24: v = i.a & i.b;
        6'h25: v = i.a | i.b;
        6'h20, 6'h21: v = i.a + i.b;
        6'h26: v = i.a ^ i.b;
        6'h22: v = i.a - i.b;
        6'h2A: v = ($signed(i.a) < $signed(i.b)) ? 32'h1 : 32'h0;
        6'h2B: v = (i.a < i.b) ? 32'h1 : 32'h0;
        6'h19: begin
          v = p[31:0];
`ifdef ALU_ISSUE_HILO_EN
          hi_m = p[63:32];
          lo_m = p[31:0];
`endif
        end
        6'h00, 6'h02, 6'h03: begin
          ok = (i.sh == 5'd1) || (i.sh == 5'd2) || (i.sh == 5'd8);
          if (i.fn == 6'h00)      v = i.b << i.sh;
          else if (i.fn == 6'h02) v = i.b >> i.sh;
          else                    v = 32'($signed(i.b) >>> i.sh);
        end
`ifdef ALU_ISSUE_HILO_EN
        6'h10: v = hi_m;
        6'h12: v = lo_m;
`endif
        default: ok = 1'b0;
      endcase
    end else begin
      case (i.op)
        6'h08, 6'h09: v = i.a + sx;
        6'h0A: v = ($signed(i.a) < $signed(sx)) ? 32'h1 : 32'h0;
        6'h0B: v = (i.a < sx) ? 32'h1 : 32'h0;
        6'h0C: v = i.a & zx;
        6'h0D: v = i.a | zx;
        6'h0E: v = i.a ^ zx;
        6'h0F: v = {i.im, 16'h0};
        default: ok = 1'b0;
      endcase
    end
    e.data = ok ? v : 32'h0;
    e.zero = ok && (v == 32'h0);
    e.ill  = !ok;
    return e;
  endfunction

  // Drive one instruction into the EXEC_CYCLES=1 instance; returns #1 after the accepting edge
  task automatic send1(input ins_t i);
    int n;
    n = 0;
    while (!in_ready1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    opcode = i.op; funct = i.fn; shamt = i.sh; rs_val = i.a; rt_val = i.b; imm = i.im;
    in_valid1 = 1'b1;
    exp_q.push_back(ref_exec(i));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  // Wait (bounded) for a result, sample it, pop the matching expectation and complete the handshake
  task automatic recv1(output exp_t obs, output exp_t e, output int lat, output bit got);
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    obs = {out_data1, out_zero1, out_illegal1};
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (got) begin
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n1 = 1'b1; rst_n4 = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0; out_ready1 = 1'b0; out_ready4 = 1'b0;
    opcode = '0; funct = '0; shamt = '0; rs_val = '0; rt_val = '0; imm = '0;
    #2;
    rst_n1 = 1'b0; rst_n4 = 1'b0;
    #1;
    nchk++;
    if ({in_ready1, out_valid1, alu_ctrl1, alu_a1, alu_b1, out_data1, out_zero1, out_illegal1} !== {1'b1, 1'b0, 6'h0, 96'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state1: rdy=%b vld=%b ctrl=%h a=%h b=%h d=%h z=%b il=%b, want rdy=1 and all else 0",
               in_ready1, out_valid1, alu_ctrl1, alu_a1, alu_b1, out_data1, out_zero1, out_illegal1);
    end
    nchk++;
    if ({in_ready4, out_valid4, alu_ctrl4, out_data4} !== {1'b1, 1'b0, 6'h0, 32'h0}) begin
      nerr++;
      $display("FAIL reset_state4: rdy=%b vld=%b ctrl=%h d=%h, want 1 0 00 00000000", in_ready4, out_valid4, alu_ctrl4, out_data4);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n4 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addu();
    exp_t obs, e;
    int   lat;
    bit   got;
    send1('{6'h00, 6'h21, 5'd0, 32'h7FFFFFFF, 32'h00000001, 16'h0});
    nchk++;
    if ({alu_ctrl1, alu_a1, alu_b1} !== {6'h03, 32'h7FFFFFFF, 32'h1}) begin
      nerr++;
      $display("FAIL addu_issue: ctrl=%h a=%h b=%h, want 03 7fffffff 00000001", alu_ctrl1, alu_a1, alu_b1);
    end
    nchk++;
    if (in_ready1 !== 1'b0) begin
      nerr++;
      $display("FAIL addu_busy: in_ready=%b, want 0", in_ready1);
    end
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || lat != 2) begin
      nerr++;
      $display("FAIL addu_latency: got=%0d lat=%0d, want valid after 2", got, lat);
    end
    nchk++;
    if (obs !== e || obs !== {32'h80000000, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL addu_result: {d,z,il}=%h, want %h", obs, e);
    end
  endtask

  task automatic test_sub_zero();
    exp_t obs, e;
    int   lat;
    bit   got;
    send1('{6'h00, 6'h22, 5'd0, 32'h1234, 32'h1234, 16'h0});
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || obs !== e || obs !== {32'h0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL sub_zero: got=%0d {d,z,il}=%h, want %h", got, obs, e);
    end
  endtask

  task automatic test_illegal_shift();
    exp_t obs, e;
    int   lat;
    bit   got;
    send1('{6'h00, 6'h00, 5'd3, 32'h1, 32'h1, 16'h0});
    nchk++;
    if (!out_valid1 || out_illegal1 !== 1'b1 || alu_ctrl1 !== 6'h06) begin
      nerr++;
      $display("FAIL sll3_next_cycle: vld=%b il=%b ctrl=%h, want 1 1 06", out_valid1, out_illegal1, alu_ctrl1);
    end
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || lat != 1 || obs !== e || obs !== {32'h0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL sll3_result: lat=%0d {d,z,il}=%h, want lat 1 %h", lat, obs, e);
    end
  endtask

  task automatic test_imm();
    exp_t obs, e;
    int   lat;
    bit   got;
    send1('{6'h0D, 6'h00, 5'd0, 32'h0, 32'hDEAD, 16'h8000});
    nchk++;
    if (alu_b1 !== 32'h00008000 || alu_ctrl1 !== 6'h01) begin
      nerr++;
      $display("FAIL ori_operand: b=%h ctrl=%h, want 00008000 01", alu_b1, alu_ctrl1);
    end
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || obs !== e || obs[33:2] !== 32'h00008000) begin
      nerr++;
      $display("FAIL ori_result: {d,z,il}=%h, want %h", obs, e);
    end
    send1('{6'h08, 6'h00, 5'd0, 32'h0, 32'hDEAD, 16'h8000});
    nchk++;
    if (alu_b1 !== 32'hFFFF8000 || alu_ctrl1 !== 6'h02) begin
      nerr++;
      $display("FAIL addi_operand: b=%h ctrl=%h, want ffff8000 02", alu_b1, alu_ctrl1);
    end
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || obs !== e) begin
      nerr++;
      $display("FAIL addi_result: {d,z,il}=%h, want %h", obs, e);
    end
  endtask

  task automatic test_patterns();
    ins_t tbl[18];
    exp_t obs, e;
    int   lat;
    bit   got;
    tbl[0]  = '{6'h00, 6'h24, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0};
    tbl[1]  = '{6'h00, 6'h25, 5'd0, 32'hF0F0F0F0, 32'h0F000F00, 16'h0};
    tbl[2]  = '{6'h00, 6'h26, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0};
    tbl[3]  = '{6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h00000001, 16'h0};
    tbl[4]  = '{6'h00, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h00000001, 16'h0};
    tbl[5]  = '{6'h00, 6'h00, 5'd8, 32'h0, 32'h12345678, 16'h0};
    tbl[6]  = '{6'h00, 6'h02, 5'd2, 32'h0, 32'h80000000, 16'h0};
    tbl[7]  = '{6'h00, 6'h03, 5'd1, 32'h0, 32'h80000000, 16'h0};
    tbl[8]  = '{6'h00, 6'h03, 5'd4, 32'h0, 32'h80000000, 16'h0};
    tbl[9]  = '{6'h00, 6'h20, 5'd0, 32'h00000010, 32'hFFFFFFF0, 16'h0};
    tbl[10] = '{6'h0F, 6'h00, 5'd0, 32'h12345678, 32'h0, 16'hABCD};
    tbl[11] = '{6'h0E, 6'h00, 5'd0, 32'hFFFF0000, 32'h0, 16'hFFFF};
    tbl[12] = '{6'h0A, 6'h00, 5'd0, 32'hFFFFFFFE, 32'h0, 16'hFFFF};
    tbl[13] = '{6'h0B, 6'h00, 5'd0, 32'h00000005, 32'h0, 16'hFFFF};
    tbl[14] = '{6'h0C, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h0, 16'h8001};
    tbl[15] = '{6'h23, 6'h21, 5'd0, 32'h1, 32'h1, 16'h1};
    tbl[16] = '{6'h00, 6'h3F, 5'd0, 32'h1, 32'h1, 16'h0};
    tbl[17] = '{6'h09, 6'h00, 5'd0, 32'h00000001, 32'h0, 16'hFFFF};
    for (int k = 0; k < 18; k++) begin
      send1(tbl[k]);
      recv1(obs, e, lat, got);
      nchk++;
      if (!got || obs !== e) begin
        nerr++;
        $display("FAIL pattern_%0d: got=%0d {d,z,il}=%h, want %h", k, got, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    ins_t i;
    exp_t obs, e;
    int   lat;
    bit   got;
    logic [5:0] fns[6];
    fns = '{6'h24, 6'h25, 6'h21, 6'h26, 6'h22, 6'h2A};
    for (int k = 0; k < 8; k++) begin
      i = '{6'h00, fns[$urandom_range(0, 5)], 5'd0, $urandom, $urandom, 16'h0};
      send1(i);
      recv1(obs, e, lat, got);
      nchk++;
      if (!got || lat != 2 || obs !== e) begin
        nerr++;
        $display("FAIL random_%0d: lat=%0d {d,z,il}=%h, want lat 2 %h", k, lat, obs, e);
      end
    end
  endtask

  task automatic test_hilo();
    exp_t obs, e;
    int   lat;
    bit   got;
    send1('{6'h00, 6'h19, 5'd0, 32'hFFFFFFFF, 32'h00000002, 16'h0});
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || obs !== e || obs[33:2] !== 32'hFFFFFFFE) begin
      nerr++;
      $display("FAIL multu_lo: {d,z,il}=%h, want %h", obs, e);
    end
    send1('{6'h00, 6'h10, 5'd0, 32'h0, 32'h0, 16'h0});
    recv1(obs, e, lat, got);
    nchk++;
`ifdef ALU_ISSUE_HILO_EN
    if (!got || lat != 1 || obs !== e || obs !== {32'h00000001, 1'b0, 1'b0}) begin
`else
    if (!got || lat != 1 || obs !== e || obs !== {32'h0, 1'b0, 1'b1}) begin
`endif
      nerr++;
      $display("FAIL mfhi: lat=%0d {d,z,il}=%h, want lat 1 %h", lat, obs, e);
    end
    send1('{6'h00, 6'h12, 5'd0, 32'h0, 32'h0, 16'h0});
    recv1(obs, e, lat, got);
    nchk++;
    if (!got || lat != 1 || obs !== e) begin
      nerr++;
      $display("FAIL mflo: lat=%0d {d,z,il}=%h, want lat 1 %h", lat, obs, e);
    end
  endtask

  task automatic test_exec4_hold_reset();
    int lat;
    bit seen;
    opcode = 6'h00; funct = 6'h21; shamt = 5'd0; rs_val = 32'd5; rt_val = 32'd7; imm = 16'h0;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 1;
    for (int k = 0; k < 20 && !out_valid4; k++) begin
      @(posedge clk); #1;
      lat++;
    end
    nchk++;
    if (!out_valid4 || lat != 5 || out_data4 !== 32'd12 || out_zero4 !== 1'b0) begin
      nerr++;
      $display("FAIL exec4_result: vld=%b lat=%0d d=%h, want 1 5 0000000c", out_valid4, lat, out_data4);
    end
    funct = 6'h22; rs_val = 32'd9; rt_val = 32'd9;
    in_valid4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      nchk++;
      if (!out_valid4 || out_data4 !== 32'd12 || alu_ctrl4 !== 6'h03) begin
        nerr++;
        $display("FAIL exec4_hold_%0d: vld=%b d=%h ctrl=%h, want 1 0000000c 03", k, out_valid4, out_data4, alu_ctrl4);
      end
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    nchk++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      nerr++;
      $display("FAIL exec4_release: vld=%b rdy=%b, want 0 1", out_valid4, in_ready4);
    end
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #2;
    rst_n4 = 1'b0;
    #1;
    nchk++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || alu_ctrl4 !== 6'h00) begin
      nerr++;
      $display("FAIL exec4_async_reset: vld=%b rdy=%b ctrl=%h, want 0 1 00", out_valid4, in_ready4, alu_ctrl4);
    end
    @(negedge clk);
    rst_n4 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid4) seen = 1'b1;
    end
    nchk++;
    if (seen || in_ready4 !== 1'b1) begin
      nerr++;
      $display("FAIL exec4_discard: out_valid seen=%b rdy=%b, want 0 1", seen, in_ready4);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_sub_zero();
    test_illegal_shift();
    test_imm();
    test_patterns();
    test_back_to_back();
    test_hilo();
    test_exec4_hold_reset();
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
